// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the adder-sharing scheduler and its arbiter.
package adder_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_WORDS = 4;

  // Index width for n items; never below one bit so ports stay legal at n=2.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr wins.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  always_comb begin
    int w_cand;
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    // Walk from the farthest candidate back to i_ptr so the nearest one wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (i_req[ID_W'(w_cand)]) begin
        o_grant                  = '0;
        o_grant[ID_W'(w_cand)]   = 1'b1;
        o_idx                    = ID_W'(w_cand);
        o_valid                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_sched.sv
// Shares one external combinational adder among NUM_REQ requesters, locking it
// for a whole multi-word transaction and chaining carry between words.
module adder_share_sched
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int ID_W      = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       global_resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_cin,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_cout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_last,
  output logic                       err_overrun
);

  localparam int CNT_W = id_width(MAX_WORDS);

  state_e             r_state;
  logic [ID_W-1:0]    r_grant;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_first_word;
  logic               r_carry;
  logic [CNT_W-1:0]   r_word_cnt;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [ID_W-1:0]    w_arb_idx;
  logic               w_arb_valid;
  logic               w_busy;
  logic               w_slot_free;
  logic               w_accept;
  logic               w_last_g;
  logic               w_final;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_busy      = (r_state == BUSY);
  assign w_slot_free = !rsp_valid || rsp_ready;
  assign w_accept    = w_busy && req_valid[r_grant] && w_slot_free;
  assign w_last_g    = req_last[r_grant];
  // A transaction that never raises last is cut off at MAX_WORDS.
  assign w_final     = w_last_g || (r_word_cnt == CNT_W'(MAX_WORDS - 1));

  assign req_ready = r_grant_oh & {NUM_REQ{w_busy && w_slot_free}};

  // Operands are zeroed while idle so the shared adder sees no stray requester data.
  assign add_a   = w_busy ? req_a[r_grant*WIDTH +: WIDTH] : '0;
  assign add_b   = w_busy ? req_b[r_grant*WIDTH +: WIDTH] : '0;
  assign add_cin = w_busy && (r_first_word ? req_cin[r_grant] : r_carry);

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_grant_oh   <= '0;
      r_rr_ptr     <= '0;
      r_first_word <= 1'b1;
      r_carry      <= 1'b0;
      r_word_cnt   <= '0;
      rsp_valid    <= 1'b0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_id       <= '0;
      rsp_last     <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      err_overrun <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_grant      <= w_arb_idx;
            r_grant_oh   <= w_arb_grant;
            r_first_word <= 1'b1;
            r_word_cnt   <= '0;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept) begin
            r_carry      <= add_cout;
            r_first_word <= 1'b0;
            r_word_cnt   <= r_word_cnt + CNT_W'(1);
            if (w_final) begin
              r_rr_ptr    <= (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);
              r_state     <= IDLE;
              err_overrun <= !w_last_g;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // Response register: a new word overwrites, otherwise a handshake drains it.
      if (w_accept) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= r_grant;
        rsp_last  <= w_final;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed bench for adder_share_sched with a behavioural a+b+cin adder on add_*.
module tb_adder_share_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     global_resetn;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [NUM_REQ-1:0]       req_last;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_last;
  logic                     err_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  adder_share_sched #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_WORDS (4)
  ) dut (
    .clk           (clk),
    .global_resetn (global_resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_cin       (req_cin),
    .req_last      (req_last),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_cin       (add_cin),
    .add_sum       (add_sum),
    .add_cout      (add_cout),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_sum       (rsp_sum),
    .rsp_cout      (rsp_cout),
    .rsp_id        (rsp_id),
    .rsp_last      (rsp_last),
    .err_overrun   (err_overrun)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic last);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
    req_last[i]             = last;
    req_valid[i]            = 1'b1;
  endtask

  task automatic apply_reset();
    global_resetn = 1'b0;
    req_valid = '0;
    tick();
    global_resetn = 1'b1;
  endtask

  task automatic test_reset();
    global_resetn = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_last = '0;
    rsp_ready = 1'b1;
    tick(); tick();
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_tests++; if (rsp_sum !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
    n_tests++; if ({rsp_cout, rsp_id, rsp_last, err_overrun} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {rsp_cout, rsp_id, rsp_last, err_overrun}); end
    n_tests++; if (add_a !== 32'h0) begin n_fail++; $display("FAIL reset_add_a: got %h want 0", add_a); end
    global_resetn = 1'b1;
  endtask

  task automatic test_single_word();
    set_word(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
    tick();
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    n_tests++; if (rsp_sum !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL single_sum: got %h want ffffffff", rsp_sum); end
    n_tests++; if ({rsp_cout, rsp_id, rsp_last} !== 4'b0_00_1) begin n_fail++; $display("FAIL single_cout_id_last: got %b want 0001", {rsp_cout, rsp_id, rsp_last}); end
    tick();
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_carry_chain();
    set_word(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick(); tick();
    n_tests++; if (rsp_sum !== 32'h0) begin n_fail++; $display("FAIL chain_w0_sum: got %h want 0", rsp_sum); end
    n_tests++; if ({rsp_cout, rsp_id, rsp_last} !== 4'b1_01_0) begin n_fail++; $display("FAIL chain_w0_cout_id_last: got %b want 1010", {rsp_cout, rsp_id, rsp_last}); end
    set_word(1, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    req_valid = '0;
    n_tests++; if (rsp_sum !== 32'h1) begin n_fail++; $display("FAIL chain_w1_sum: got %h want 1", rsp_sum); end
    n_tests++; if ({rsp_cout, rsp_last} !== 2'b01) begin n_fail++; $display("FAIL chain_w1_cout_last: got %b want 01", {rsp_cout, rsp_last}); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0]  exp_id  [6];
    logic [31:0]      exp_sum [6];
    bit got;
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    exp_sum = '{32'h101, 32'h202, 32'h303, 32'h404, 32'hF, 32'h31};
    apply_reset();
    set_word(0, 32'h1, 32'h100, 1'b0, 1'b1);
    set_word(1, 32'h2, 32'h200, 1'b0, 1'b1);
    set_word(2, 32'h3, 32'h300, 1'b0, 1'b1);
    set_word(3, 32'h4, 32'h400, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      if (j == 4) begin
        tick();
        set_word(0, 32'h7, 32'h8, 1'b0, 1'b1);
        set_word(2, 32'h10, 32'h20, 1'b1, 1'b1);
      end
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (rsp_valid) begin got = 1'b1; break; end
      end
      n_tests++; if (!got) begin n_fail++; $display("FAIL rr_timeout_%0d: got no response want id %0d", j, exp_id[j]); end
      if (got) begin
        req_valid[rsp_id] = 1'b0;
        n_tests++; if (rsp_id !== exp_id[j]) begin n_fail++; $display("FAIL rr_id_%0d: got %0d want %0d", j, rsp_id, exp_id[j]); end
        n_tests++; if (rsp_sum !== exp_sum[j]) begin n_fail++; $display("FAIL rr_sum_%0d: got %h want %h", j, rsp_sum, exp_sum[j]); end
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    set_word(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    tick(); tick();
    n_tests++; if ({rsp_valid, rsp_cout, rsp_sum} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL bp_w0: got %b/%b/%h want 1/1/0", rsp_valid, rsp_cout, rsp_sum); end
    rsp_ready = 1'b0;
    set_word(1, 32'h1, 32'h2, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 0000", c, req_ready); end
      n_tests++; if ({rsp_valid, rsp_cout, rsp_id, rsp_last, rsp_sum} !== {1'b1, 1'b1, 2'd1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL bp_hold_%0d: got %b%b%0d%b %h want 1110 0", c, rsp_valid, rsp_cout, rsp_id, rsp_last, rsp_sum); end
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if ({rsp_sum, rsp_cout, rsp_last} !== {32'h4, 1'b0, 1'b1}) begin n_fail++; $display("FAIL bp_w1: got %h/%b/%b want 4/0/1", rsp_sum, rsp_cout, rsp_last); end
    tick();
  endtask

  task automatic test_overrun();
    set_word(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd3, 1'b1, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL ovr_word_%0d: got %b/%0d/%b/%h want 1/3/1/ffffffff", k, rsp_valid, rsp_id, rsp_cout, rsp_sum); end
      n_tests++; if ({rsp_last, err_overrun} !== {2{k == 3}}) begin n_fail++; $display("FAIL ovr_flags_%0d: got last=%b err=%b want %b", k, rsp_last, err_overrun, (k == 3)); end
    end
    tick();
    n_tests++; if ({err_overrun, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL ovr_pulse_end: got err=%b valid=%b want 0/0", err_overrun, rsp_valid); end
    tick();
    n_tests++; if ({rsp_valid, rsp_cout, rsp_last, rsp_sum} !== {3'b110, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL ovr_word5: got %b/%b/%b/%h want 1/1/0/ffffffff", rsp_valid, rsp_cout, rsp_last, rsp_sum); end
    set_word(3, 32'h1, 32'h1, 1'b0, 1'b1);
    tick();
    req_valid = '0;
    n_tests++; if ({rsp_sum, rsp_cout, rsp_last, err_overrun} !== {32'h3, 3'b010}) begin n_fail++; $display("FAIL ovr_close: got %h/%b/%b/%b want 3/0/1/0", rsp_sum, rsp_cout, rsp_last, err_overrun); end
    tick();
  endtask

  task automatic test_reset_mid_txn();
    set_word(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    tick(); tick();
    n_tests++; if ({rsp_cout, rsp_sum} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rst_w1: got %b/%h want 1/0", rsp_cout, rsp_sum); end
    set_word(2, 32'h10, 32'h20, 1'b0, 1'b0);
    #2;
    global_resetn = 1'b0;
    #1;
    req_valid = '0;
    n_tests++; if ({rsp_valid, rsp_cout, rsp_id, rsp_last, err_overrun, req_ready} !== 10'b0) begin n_fail++; $display("FAIL rst_async_flags: got %b want 0", {rsp_valid, rsp_cout, rsp_id, rsp_last, err_overrun, req_ready}); end
    n_tests++; if (rsp_sum !== 32'h0) begin n_fail++; $display("FAIL rst_async_sum: got %h want 0", rsp_sum); end
    tick();
    global_resetn = 1'b1;
    set_word(2, 32'h5, 32'h6, 1'b0, 1'b1);
    tick(); tick();
    req_valid = '0;
    n_tests++; if ({rsp_valid, rsp_id, rsp_last, rsp_cout, rsp_sum} !== {1'b1, 2'd2, 2'b10, 32'hB}) begin n_fail++; $display("FAIL rst_fresh: got %b/%0d/%b/%b/%h want 1/2/1/0/b", rsp_valid, rsp_id, rsp_last, rsp_cout, rsp_sum); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_carry_chain();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_reset_mid_txn();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_sched.md
# adder_share_sched

Round-robin scheduler that shares one combinational 32-bit full adder (a, b, cin → sum, cout) among NUM_REQ requesters inside the fabric user design. Each requester submits a multi-word addition as a stream of words. The scheduler locks the adder to that requester until its last word, chaining the registered carry-out of each word into the next word's carry-in. Results return on a single registered response channel tagged with the requester id.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, adder word width
- MAX_WORDS, 4, maximum words per transaction before forced release
- ID_W, $clog2(NUM_REQ), response id width (derived; not overridden)

Ports:
- clk  in  1  single clock, rising edge
- global_resetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  word valid, one bit per requester
- req_ready  out  NUM_REQ  word accepted on clk edge when valid&ready
- req_a  in  NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_cin  in  NUM_REQ  carry-in, sampled only on the first word of a transaction
- req_last  in  NUM_REQ  marks the final word of a transaction
- add_a, add_b  out  WIDTH  operands to the shared adder
- add_cin  out  1  carry to the shared adder
- add_sum  in  WIDTH  adder result (combinational from add_*)
- add_cout  in  1  adder carry-out
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted on clk edge when valid&ready
- rsp_sum  out  WIDTH  registered add_sum
- rsp_cout  out  1  registered add_cout
- rsp_id  out  ID_W  requester index
- rsp_last  out  1  final word of a transaction
- err_overrun  out  1  one-cycle pulse on a forced release at MAX_WORDS

## Operation
- FSM states: IDLE and BUSY.
- IDLE: if any req_valid is set, a round-robin pick starts at pointer rr_ptr. The grant g is registered, first_word is set to 1, word_cnt is cleared, and the FSM goes to BUSY. req_ready is all-zero in IDLE.
- BUSY: req_ready[g] = !rsp_valid || rsp_ready. All other req_ready bits are 0.
- add_a/add_b are muxed from requester g.
- add_cin = first_word ? req_cin[g] : carry_q.
- Word accept (req_valid[g] && req_ready[g]):
  - rsp_sum ← add_sum, rsp_cout ← add_cout, rsp_id ← g, rsp_valid ← 1.
  - carry_q ← add_cout, first_word ← 0, word_cnt++.
- A word is final when req_last[g] is set or word_cnt == MAX_WORDS-1. On a final word:
  - rsp_last ← 1
  - rr_ptr ← g+1 mod NUM_REQ
  - FSM → IDLE
  - if req_last[g] was 0, pulse err_overrun.
- Response: rsp_valid clears on rsp_ready when no new word is accepted in the same cycle. Accept and drain in the same cycle keeps rsp_valid=1 with the new data.
- Fairness: a requester served in one transaction has lowest priority in the next arbitration. Requesters that deassert valid while ungranted lose nothing.
- Requester g deasserting req_valid mid-transaction stalls BUSY indefinitely. There is no timeout.
- Carry never leaks between transactions: first_word forces req_cin.

## Timing
- Reset (global_resetn low, async) clears all of the following:
  - req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last, err_overrun
  - carry_q, word_cnt, rr_ptr
  - FSM returns to IDLE.
- Reset mid-transaction drops the transaction and any pending response.
- Latency:
  - req_valid rising in IDLE at cycle N → grant at edge N+1 → word accepted at edge N+2 (if the response slot is free) → rsp_valid high in cycle N+2.
  - Subsequent words: one per cycle with rsp_ready held high.
- One IDLE cycle separates consecutive transactions.
- add_* → add_sum → rsp_sum is a single-cycle combinational path. The adder is not registered.
- rsp_* are stable while rsp_valid && !rsp_ready.

## Structure
- Package adder_sched_pkg:
  - state_e enum {IDLE, BUSY}
  - localparam default WIDTH/NUM_REQ/MAX_WORDS
  - function id_width(n).
- Sub-module rr_arbiter:
  - inputs: req[NUM_REQ], ptr
  - outputs: one-hot grant and encoded index
  - purely combinational
  - reused for other shared fabric resources.
- The adder stays external. The bench instantiates a behavioural a+b+cin model on add_*.

## Test plan
- Single word, req0: a=AAAAAAAA, b=55555555, cin=0 → rsp_sum=FFFFFFFF, cout=0, id=0, last=1, rsp_valid two cycles after req_valid.
- Two-word chain, req1:
  - word0 a=FFFFFFFF, b=00000001, cin=0 → sum=00000000, cout=1
  - word1 a=0, b=0, last=1 → sum=00000001, cout=0 (carry chained).
- All four requesters valid with single words from reset → responses id 0,1,2,3 in order. Then req0 and req2 valid with rr_ptr=0 → 0, then 2.
- Backpressure: rsp_ready low for 3 cycles mid two-word transaction → req_ready[g]=0, rsp_* held constant. The second word is accepted the cycle rsp_ready rises.
- Overrun, MAX_WORDS=4: req3 sends 5 words, all a=b=FFFFFFFF, cin=1, no last:
  - word 4 → rsp_last=1 and an err_overrun pulse
  - word 5 → starts a new transaction using req_cin=1, sum=FFFFFFFF, cout=1.
- Reset asserted during word 2 of 3 → all outputs 0 immediately. After release, a fresh transaction on req2 with cin=0 gives the correct sum (no stale carry).
